// File: rtl/telem_pipe_slice.sv
// ============================================================================
// telem_pipe_slice
// ----------------------------------------------------------------------------
// Elastic pipeline register for the Rice decoder datapath. It sits between the
// bitstream unpacker, the Rice decode core and the sample output formatter.
// The word width and number of stages are set by parameters. Every stage pairs
// a main register with a skid register, so the slice can run at one word per
// cycle while the downstream side applies backpressure, and all ready signals
// still come straight from flops.
//
// Parameters:
//   WIDTH      data word width in bits (1..128)
//   DEPTH      number of register stages (1..8); holds up to 2*DEPTH words
//   RESET_DATA value loaded into every data register on reset
//   OCC_W      occupancy port width, derived from DEPTH
//
// Ports:
//   clk        rising-edge clock for all logic
//   reset      synchronous, active-low reset
//   flush      synchronous discard of every held word
//   in_valid   upstream word valid
//   in_ready   slice can take a word this cycle (0 while reset or flush)
//   in_data    upstream word
//   out_valid  word available at the output
//   out_ready  downstream takes the output word this cycle
//   out_data   output word (meaningful only while out_valid is 1)
//   occupancy  number of words currently held (0..2*DEPTH)
//
// Optional feature, macro PIPE_PARITY_EN:
//   When defined, each stored word carries an even-parity bit computed from
//   in_data at the input. The macro also adds three ports:
//     par_inject      inverts the stored parity of the word accepted this cycle
//     par_err         out_valid and a parity mismatch on the output word
//     par_err_sticky  set by an output handshake that has par_err; cleared by
//                     reset or flush
//   When the macro is undefined these ports do not exist and no parity bit is
//   stored.
// ============================================================================
module telem_pipe_slice #(
   parameter int              WIDTH      = 32,
   parameter int              DEPTH      = 2,
   parameter logic [WIDTH-1:0] RESET_DATA = '0,
   localparam int             OCC_W      = $clog2(2*DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OCC_W-1:0] occupancy
`ifdef PIPE_PARITY_EN
   ,
   input  logic             par_inject,
   output logic             par_err,
   output logic             par_err_sticky
`endif
);

`ifdef PIPE_PARITY_EN
   // Each stored word holds the parity bit above the data bits.
   localparam int SW = WIDTH + 1;
   localparam logic [SW-1:0] RESET_WORD = {^RESET_DATA, RESET_DATA};
`else
   localparam int SW = WIDTH;
   localparam logic [SW-1:0] RESET_WORD = RESET_DATA;
`endif

   logic [SW-1:0]    main_data [DEPTH];
   logic [SW-1:0]    skid_data [DEPTH];
   logic [DEPTH-1:0] main_valid;
   logic [DEPTH-1:0] skid_valid;
   logic [SW-1:0]    in_word;
   logic             in_hs;
   logic             out_hs;

`ifdef PIPE_PARITY_EN
   // The even-parity bit is formed here, at the input. A set par_inject flips
   // it so that the error path can be exercised on purpose.
   assign in_word = {(^in_data) ^ par_inject, in_data};
`else
   assign in_word = in_data;
`endif

   // Stage 0 takes a word only while its skid slot is free. in_ready is also
   // held low during reset and flush, because the register update drops any
   // word offered in those cycles. out_ready does not feed this signal.
   assign in_ready  = !skid_valid[0] && reset && !flush;
   assign in_hs     = in_valid && in_ready;

   assign out_valid = main_valid[DEPTH-1];
   assign out_data  = main_data[DEPTH-1][WIDTH-1:0];
   assign out_hs    = out_valid && out_ready;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [SW-1:0] main_d;
      logic [SW-1:0] skid_d;
      logic          main_v;
      logic          skid_v;
      logic [SW-1:0] up_data;
      logic          up_valid;
      logic          down_ready;
      logic          up_hs;
      logic          down_hs;

      // Stage 0 is fed by the block input. Each later stage is fed by the
      // main register of the stage in front of it.
      if (k == 0) begin : g_first
         assign up_valid = in_valid;
         assign up_data  = in_word;
      end else begin : g_chain
         assign up_valid = main_valid[k-1];
         assign up_data  = main_data[k-1];
      end

      // The last stage answers to out_ready. An inner stage may pass a word
      // forward when the skid slot of the next stage is empty. That is a
      // registered value, so ready never ripples through the chain.
      if (k == DEPTH-1) begin : g_last
         assign down_ready = out_ready;
      end else begin : g_inner
         assign down_ready = !skid_valid[k+1];
      end

      assign up_hs   = up_valid && !skid_v;
      assign down_hs = main_v && down_ready;

      // Skid-buffer stage update. Whenever the main slot frees up, either by
      // draining downstream or by being empty already, a parked skid word
      // moves into it first. If no word is parked, the incoming word goes
      // into main. While main is held under backpressure, an incoming word
      // parks in skid. The stage refuses input while skid is occupied, so
      // skid is never overwritten.
      always_ff @(posedge clk) begin
         if (!reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= RESET_WORD;
            skid_d <= RESET_WORD;
         end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
         end else if (down_hs || !main_v) begin
            if (skid_v) begin
               main_d <= skid_d;
               main_v <= 1'b1;
               skid_v <= 1'b0;
            end else begin
               main_v <= up_hs;
               if (up_hs) begin
                  main_d <= up_data;
               end
            end
         end else if (up_hs) begin
            skid_d <= up_data;
            skid_v <= 1'b1;
         end
      end

      assign main_valid[k] = main_v;
      assign skid_valid[k] = skid_v;
      assign main_data[k]  = main_d;
      assign skid_data[k]  = skid_d;
   end

   // Running count of held words. It moves only on the two block-level
   // handshakes, so it always matches the number of set valid bits. It is
   // cleared together with the valid bits on reset and on flush.
   always_ff @(posedge clk) begin
      if (!reset) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else begin
         case ({in_hs, out_hs})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

`ifdef PIPE_PARITY_EN
   // The parity check is combinational on the output word, so it is valid in
   // the same cycle that the word is presented.
   assign par_err = out_valid && ((^out_data) != main_data[DEPTH-1][WIDTH]);

   // The sticky flag records a bad word only once downstream has actually
   // taken it. A word that is presented but never consumed does not set it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         par_err_sticky <= 1'b0;
      end else if (flush) begin
         par_err_sticky <= 1'b0;
      end else if (out_hs && par_err) begin
         par_err_sticky <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_telem_pipe_slice.sv
// ============================================================================
// tb_telem_pipe_slice
// ----------------------------------------------------------------------------
// Self-checking bench for telem_pipe_slice (WIDTH=32, DEPTH=2). The stimulus
// side pushes every accepted word into a FIFO queue. A separate monitor pops
// that queue on every output handshake and checks occupancy against the
// queue length after every edge. Directed sequences cover latency, streaming,
// backpressure, flush and reset. A long random run follows them. When
// PIPE_PARITY_EN is defined, parity injection and the sticky flag are also
// exercised.
// ============================================================================
module tb_telem_pipe_slice;
   localparam int WIDTH = 32;
   localparam int DEPTH = 2;
   localparam int CAP   = 2 * DEPTH;
   localparam int OCC_W = $clog2(CAP + 1);
   localparam logic [WIDTH-1:0] RST_DATA = 32'hDEAD_BEEF;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [OCC_W-1:0] occupancy;
`ifdef PIPE_PARITY_EN
   logic             par_inject = 1'b0;
   logic             par_err;
   logic             par_err_sticky;
   bit               injectNext = 1'b0;
`endif

   logic [WIDTH-1:0] expQ [$];
   int               compared = 0;
   int               mismatched = 0;

   telem_pipe_slice #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .RESET_DATA(RST_DATA)
   ) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .occupancy(occupancy)
`ifdef PIPE_PARITY_EN
      ,
      .par_inject(par_inject),
      .par_err(par_err),
      .par_err_sticky(par_err_sticky)
`endif
   );

   // Free-running clock with posedges at 5, 15, 25 and so on.
   always #5 clk = ~clk;

   // Compares one value against the bench's expectation and records a
   // mismatch.
   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs on the falling edge. If the word will be
   // taken at the next rising edge, it is recorded in the reference queue.
   task automatic applyStimulus(input bit iv, input logic [WIDTH-1:0] d, input bit ordy,
                                input bit fl, input bit rstN, output bit accepted);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      reset     = rstN;
`ifdef PIPE_PARITY_EN
      par_inject = injectNext;
`endif
      #1;
      accepted = iv && in_ready;
      if (accepted) expQ.push_back(d);
   endtask

   // Idles with out_ready high until the reference queue is empty.
   task automatic drain();
      bit acc;
      int budget = 0;
      while (expQ.size() != 0 && budget < 100) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
         budget++;
      end
      checkOutput("drainComplete", WIDTH'(expQ.size()), '0);
   endtask

   // Scoreboard monitor. Shortly before each rising edge it works out the
   // output handshake and pops the queue on it. Reset and flush then empty
   // the queue. Just after the edge it checks the visible state against the
   // queue.
   initial begin
      bit wasReset;
      forever begin
         @(negedge clk);
         #2;
         if (occupancy == OCC_W'(CAP)) checkOutput("fullBlocksInput", WIDTH'(in_ready), '0);
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpectedOutput: got %0h, expected no word at %0t", out_data, $time);
            end else begin
               checkOutput("outOrder", out_data, expQ.pop_front());
            end
         end
         if (!reset || flush) expQ.delete();
         wasReset = !reset;
         @(posedge clk);
         #1;
         checkOutput("occupancy", WIDTH'(occupancy), WIDTH'(expQ.size()));
         if (expQ.size() == 0) checkOutput("outValidWhenEmpty", WIDTH'(out_valid), '0);
         else if (out_valid) checkOutput("outFront", out_data, expQ[0]);
         if (wasReset) checkOutput("resetOutData", out_data, RST_DATA);
      end
   end

   initial begin
      bit acc;
      int accCount;
      int w;
      int budget;

      // Hold reset for two cycles.
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
      checkOutput("resetOutValid", WIDTH'(out_valid), '0);
      checkOutput("resetOccupancy", WIDTH'(occupancy), '0);
      checkOutput("resetData", out_data, RST_DATA);
      checkOutput("inReadyDuringReset", WIDTH'(in_ready), '0);

      // A single word shows up after DEPTH cycles, then the slice empties.
      applyStimulus(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b1, acc);
      checkOutput("firstAccepted", WIDTH'(acc), WIDTH'(1));
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
      checkOutput("latencyNotYet", WIDTH'(out_valid), '0);
      checkOutput("latencyOcc1", WIDTH'(occupancy), WIDTH'(1));
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
      checkOutput("latencyValid", WIDTH'(out_valid), WIDTH'(1));
      checkOutput("latencyData", out_data, 32'hA5A5_0001);
      checkOutput("latencyOccStill1", WIDTH'(occupancy), WIDTH'(1));
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
      checkOutput("latencyOccBack0", WIDTH'(occupancy), '0);
      checkOutput("latencyValidGone", WIDTH'(out_valid), '0);

      // A back-to-back stream must never be stalled and must come out at
      // full rate.
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, WIDTH'(i + 1), 1'b1, 1'b0, 1'b1, acc);
         checkOutput("streamInReady", WIDTH'(in_ready), WIDTH'(1));
         if (i >= DEPTH) checkOutput("streamThroughput", WIDTH'(out_valid), WIDTH'(1));
      end
      drain();

      // Under backpressure, exactly 2*DEPTH words fit and the head word
      // holds steady.
      accCount = 0;
      w = 1;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, WIDTH'(w), 1'b0, 1'b0, 1'b1, acc);
         if (acc) begin
            accCount++;
            w++;
         end
      end
      checkOutput("fullAcceptCount", WIDTH'(accCount), WIDTH'(CAP));
      checkOutput("fullOccupancy", WIDTH'(occupancy), WIDTH'(CAP));
      checkOutput("fullInReady", WIDTH'(in_ready), '0);
      checkOutput("fullHeadValid", WIDTH'(out_valid), WIDTH'(1));
      checkOutput("fullHeadData", out_data, WIDTH'(1));
      budget = 0;
      while (w <= 5 && budget < 20) begin
         applyStimulus(1'b1, WIDTH'(w), 1'b1, 1'b0, 1'b1, acc);
         if (acc) w++;
         budget++;
      end
      checkOutput("fifthWordAccepted", WIDTH'(w), WIDTH'(6));
      drain();

      // Flush while three words are held. The word offered with flush is
      // dropped.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'(32'h100 + i), 1'b0, 1'b0, 1'b1, acc);
      applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1, 1'b1, acc);
      checkOutput("flushDropsInput", WIDTH'(acc), '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
      checkOutput("flushOccupancy", WIDTH'(occupancy), '0);
      checkOutput("flushOutValid", WIDTH'(out_valid), '0);
      applyStimulus(1'b1, 32'h0000_0077, 1'b1, 1'b0, 1'b1, acc);
      drain();

      // Reset in the middle of a transfer loses the held words.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'(32'h200 + i), 1'b0, 1'b0, 1'b1, acc);
      applyStimulus(1'b1, 32'hBAD1_BAD1, 1'b0, 1'b0, 1'b0, acc);
      checkOutput("resetDropsInput", WIDTH'(acc), '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
      checkOutput("midResetOutValid", WIDTH'(out_valid), '0);
      checkOutput("midResetOutData", out_data, RST_DATA);
      checkOutput("midResetOccupancy", WIDTH'(occupancy), '0);

`ifdef PIPE_PARITY_EN
      // An injected parity error is flagged at the output and becomes sticky
      // after the handshake. A clean word leaves the sticky flag set, and
      // flush clears it.
      injectNext = 1'b1;
      applyStimulus(1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b1, acc);
      injectNext = 1'b0;
      budget = 0;
      while (!out_valid && budget < 10) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
         budget++;
      end
      checkOutput("parWordPresent", out_data, 32'h0000_0003);
      checkOutput("parErrFlagged", WIDTH'(par_err), WIDTH'(1));
      checkOutput("parStickyBefore", WIDTH'(par_err_sticky), '0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
      applyStimulus(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b1, acc);
      checkOutput("parStickySet", WIDTH'(par_err_sticky), WIDTH'(1));
      budget = 0;
      while (!out_valid && budget < 10) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
         budget++;
      end
      checkOutput("parCleanWord", out_data, 32'h0000_0005);
      checkOutput("parCleanNoErr", WIDTH'(par_err), '0);
      checkOutput("parStickyHeld", WIDTH'(par_err_sticky), WIDTH'(1));
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
      checkOutput("parStickyFlushed", WIDTH'(par_err_sticky), '0);
`endif

      // Random traffic with occasional flush and reset, checked by the
      // monitor every cycle.
      for (int c = 0; c < 10000; c++) begin
         applyStimulus($urandom_range(99) < 70, WIDTH'($urandom), $urandom_range(99) < 60,
                       $urandom_range(299) == 0, $urandom_range(699) != 0, acc);
      end
      drain();

      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
